mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle RV32 core's data and instruction requests. The core's control unit issues one word request at a time. This block accepts the request, range- and alignment-checks it, and sequences the synchronous block RAM (registered output, regce). It then returns one response pulse carrying read data or an error flag. It sits between the core datapath and the RAM instance, replacing the direct databus-to-RAM connection.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; RAM holds 2^ADDR_W 32-bit words
- BASE, 32'h0000_0000, byte address mapped to RAM word 0
- READ_LAT, 2, cycles from ram_addr presented to ram_dout valid; legal range 1..3

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  read data; held until the next response
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range access
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_regce  out  1  RAM output-register clock enable
- ram_dout  in  32  RAM read data

## Operation
- States: IDLE, WR, RD, RESP.
- req_ready = 1 in IDLE and in RESP, 0 otherwise.
- A request is accepted on a cycle where req_valid & req_ready. On acceptance the block registers req_we, req_addr and req_wdata. A request with req_ready = 0 is ignored; the requester holds it.
- Offset = req_addr - BASE, computed as a 32-bit modular subtraction.
- An access is an error if req_addr[1:0] != 0, or if offset >= 4·2^ADDR_W.
- An error request goes directly to RESP with rsp_err = 1 and rsp_rdata = 0. No RAM access and no RAM write take place.
- Write: IDLE/RESP → WR → RESP.
  - In WR: ram_we = 1, ram_addr = offset[ADDR_W+1:2], ram_din = registered wdata.
  - In the following RESP: rsp_rdata = 0, rsp_err = 0.
- Read: IDLE/RESP → RD → RESP.
  - RD lasts READ_LAT+1 cycles, tracked by a down-counter.
  - ram_addr is held stable and ram_regce = 1 throughout RD.
  - On the last RD cycle, ram_dout is captured into rsp_rdata.
- RESP: rsp_valid = 1 for exactly one cycle.
  - If a new request is accepted in RESP, the block goes to that request's next state; otherwise it goes to IDLE.
- ram_we is 1 only in WR. ram_regce is 1 only in RD. ram_addr and ram_din hold their last values outside WR/RD.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, ram_we = 0, ram_regce = 0, ram_addr = 0, ram_din = 0, state = IDLE.
- All outputs are registered or decoded from the state register only. There are no combinational paths from req_* inputs to any output.
- Latencies, with the accept edge ending cycle T:
  - Error: rsp_valid in T+1.
  - Write: ram_we in T+1, rsp_valid in T+2.
  - Read: RD covers T+1 .. T+1+READ_LAT; rsp_valid in T+2+READ_LAT. With the default (READ_LAT = 2), rsp_valid is in T+4.
- Back-to-back throughput:
  - Writes: one every 2 cycles.
  - Reads: one every READ_LAT+2 cycles.
  - Errors: one every cycle (RESP → RESP).
- Boundaries:
  - Last word (offset = 4·2^ADDR_W - 4) is legal.
  - Next word (offset = 4·2^ADDR_W) is an error.
  - An address below BASE wraps to a large offset and is an error.
- Reset asserted mid-operation: outputs are cleared asynchronously, so ram_we drops within the same cycle. No response is issued for the aborted request. After reset deasserts, the first edge may accept a new request.

## Test plan
- Reset, then write 0xDEADBEEF to BASE+0x10; read BASE+0x10. Required: ram_we high only in T+1 with ram_addr = 4; write rsp_valid in T+2 with rsp_err = 0; read rsp_valid in T+4 with rsp_rdata = 0xDEADBEEF.
- Misaligned read at BASE+0x13, then out-of-range read at BASE+0x1000 (ADDR_W = 10). Required: each gives rsp_valid one cycle after accept, rsp_err = 1, rsp_rdata = 0, and ram_we/ram_regce never asserted.
- Last word BASE+0xFFC written with 0x12345678, then read back. Required: rsp_err = 0, data matches, ram_addr = 0x3FF.
- req_valid held high for write, read, write with no gaps. Required: each request is accepted in a RESP cycle, responses arrive in order, and no request is dropped or duplicated.
- rst asserted in the middle of RD, during a read of a location holding 0xA5A5A5A5. Required: rsp_valid never pulses for that read; all outputs read zero while rst is low; req_ready = 1 on the first cycle after release.
- Repeat the read test at READ_LAT = 1 and READ_LAT = 3. Required: rsp_valid in T+3 and T+5 respectively, and ram_regce high for exactly READ_LAT+1 cycles.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-request memory responder for the RV32 core.
// Checks each word request, sequences a registered-output block RAM.
module mem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    output logic              ram_regce,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_t;

    // Byte size of the RAM window; 33 bits so ADDR_W up to 30 cannot overflow.
    localparam logic [32:0] LIMIT    = 33'd1 << (ADDR_W + 2);
    localparam logic [1:0]  LAT_INIT = 2'(READ_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [31:0] offset;
    logic        req_err;
    logic        accept;
    logic        rd_last;

    assign offset  = req_addr - BASE;
    assign req_err = (req_addr[1:0] != 2'b00)
                  || ({1'b0, offset} >= LIMIT);
    assign accept  = req_valid && req_ready;
    assign rd_last = (state == RD) && (cnt == 2'd0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE and RESP both accept; errors skip the RAM entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                if (!accept) begin
                    state_nxt = IDLE;
                end else if (req_err) begin
                    state_nxt = RESP;
                end else if (req_we) begin
                    state_nxt = WR;
                end else begin
                    state_nxt = RD;
                end
            end
            WR: state_nxt = RESP;
            RD: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and RAM strobes decoded purely from the state register.
    always_comb begin
        req_ready = (state == IDLE) || (state == RESP);
        rsp_valid = (state == RESP);
        ram_we    = (state == WR);
        ram_regce = (state == RD);
    end

    // RAM address/data, read-latency counter and the held response fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 2'd0;
            ram_addr  <= '0;
            ram_din   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept && !req_err) begin
                ram_addr <= offset[ADDR_W+1:2];
                cnt      <= LAT_INIT;
                if (req_we) begin
                    ram_din <= req_wdata;
                end
            end else if ((state == RD) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end

            if (accept && req_err) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b1;
            end else if (state == WR) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end else if (rd_last) begin
                rsp_rdata <= ram_dout;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder.
// Three instances cover READ_LAT = 1, 2, 3; instance 1 is the main one.
module tb_mem_responder;

    localparam int          AW    = 10;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic clk;
    logic rst;

    logic          req_valid [3];
    logic          req_ready [3];
    logic          req_we    [3];
    logic [31:0]   req_addr  [3];
    logic [31:0]   req_wdata [3];
    logic          rsp_valid [3];
    logic [31:0]   rsp_rdata [3];
    logic          rsp_err   [3];
    logic [AW-1:0] ram_addr  [3];
    logic [31:0]   ram_din   [3];
    logic          ram_we    [3];
    logic          ram_regce [3];
    logic [31:0]   ram_dout  [3];

    int vectors;
    int miscompares;

    int            r_lat;
    int            r_we_cyc;
    int            r_nwe;
    int            r_nrc;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdin;
    logic [AW-1:0] r_raddr;

    logic [31:0] model [int];
    int          written [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem  [0:WORDS-1];
        logic [31:0] pipe [0:g];

        mem_responder #(
            .ADDR_W  (AW),
            .BASE    (BASE),
            .READ_LAT(g + 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .ram_addr (ram_addr[g]),
            .ram_din  (ram_din[g]),
            .ram_we   (ram_we[g]),
            .ram_regce(ram_regce[g]),
            .ram_dout (ram_dout[g])
        );

        // RAM with g+1 read pipeline stages, enabled by regce.
        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            if (ram_regce[g]) begin
                pipe[0] <= mem[ram_addr[g]];
                for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
            end
        end
        assign ram_dout[g] = pipe[g];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * WORDS));
    endfunction

    // Issue one request on instance k and observe until its response.
    task automatic do_req(input int k, input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit acc;
        int guard;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            acc = req_ready[k];
            tick();
            guard++;
        end
        req_valid[k] = 1'b0;
        r_lat = -1; r_we_cyc = -1; r_nwe = 0; r_nrc = 0;
        r_err = 1'bx; r_rdata = 'x;
        r_waddr = 'x; r_wdin = 'x; r_raddr = 'x;
        if (acc) begin
            for (int c = 1; c <= 20; c++) begin
                if (ram_we[k]) begin
                    r_nwe++;
                    r_we_cyc = c;
                    r_waddr  = ram_addr[k];
                    r_wdin   = ram_din[k];
                end
                if (ram_regce[k]) begin
                    r_nrc++;
                    r_raddr = ram_addr[k];
                end
                if (rsp_valid[k]) begin
                    r_lat   = c;
                    r_err   = rsp_err[k];
                    r_rdata = rsp_rdata[k];
                    break;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rsp_valid[k], rsp_err[k], rsp_rdata[k], ram_we[k],
                 ram_regce[k], ram_addr[k], ram_din[k]} !== '0
                || req_ready[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset[%0d] v=%b e=%b d=%h we=%b rce=%b a=%h din=%h rdy=%b want zeros rdy=1",
                         k, rsp_valid[k], rsp_err[k], rsp_rdata[k],
                         ram_we[k], ram_regce[k], ram_addr[k],
                         ram_din[k], req_ready[k]);
            end
        end
    endtask

    task automatic test_write_read();
        do_req(1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        vectors++;
        if (r_lat !== 2 || r_we_cyc !== 1 || r_nwe !== 1
            || r_waddr !== 10'h004 || r_wdin !== 32'hDEAD_BEEF
            || r_err !== 1'b0 || r_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr lat=%0d wecyc=%0d nwe=%0d a=%h din=%h e=%b d=%h want 2 1 1 004 deadbeef 0 0",
                     r_lat, r_we_cyc, r_nwe, r_waddr, r_wdin,
                     r_err, r_rdata);
        end
        do_req(1, 1'b0, BASE + 32'h10, 32'h0);
        vectors++;
        if (r_lat !== 4 || r_nrc !== 3 || r_raddr !== 10'h004
            || r_err !== 1'b0 || r_rdata !== 32'hDEAD_BEEF
            || r_nwe !== 0) begin
            miscompares++;
            $display("FAIL rd lat=%0d nrc=%0d a=%h e=%b d=%h nwe=%0d want 4 3 004 0 deadbeef 0",
                     r_lat, r_nrc, r_raddr, r_err, r_rdata, r_nwe);
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad [3];
        bad[0] = BASE + 32'h13;
        bad[1] = BASE + 32'h1000;
        bad[2] = BASE - 32'h4;
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b0, bad[i], 32'h0);
            vectors++;
            if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0
                || r_nwe !== 0 || r_nrc !== 0) begin
                miscompares++;
                $display("FAIL err[%0d] lat=%0d e=%b d=%h nwe=%0d nrc=%0d want 1 1 0 0 0",
                         i, r_lat, r_err, r_rdata, r_nwe, r_nrc);
            end
        end
    endtask

    task automatic test_last_word();
        do_req(1, 1'b1, BASE + 32'hFFC, 32'h1234_5678);
        vectors++;
        if (r_lat !== 2 || r_err !== 1'b0 || r_waddr !== 10'h3FF
            || r_wdin !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL last_wr lat=%0d e=%b a=%h din=%h want 2 0 3ff 12345678",
                     r_lat, r_err, r_waddr, r_wdin);
        end
        do_req(1, 1'b0, BASE + 32'hFFC, 32'h0);
        vectors++;
        if (r_lat !== 4 || r_err !== 1'b0 || r_raddr !== 10'h3FF
            || r_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL last_rd lat=%0d e=%b a=%h d=%h want 4 0 3ff 12345678",
                     r_lat, r_err, r_raddr, r_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic        we_t  [5];
        logic [31:0] adr_t [5];
        logic [31:0] wd_t  [5];
        logic        xe_t  [5];
        logic [31:0] xd_t  [5];
        int          lat_t [5];
        logic        ge    [5];
        logic [31:0] gd    [5];
        int          gc    [5];
        bit          in_rsp [5];
        int          acc0;
        int          idx;
        int          nrsp;
        int          exp_c;
        bit          acc_now;
        we_t[0] = 1'b1; adr_t[0] = BASE + 32'h40; wd_t[0] = $urandom;
        we_t[1] = 1'b0; adr_t[1] = BASE + 32'h40; wd_t[1] = 32'h0;
        we_t[2] = 1'b1; adr_t[2] = BASE + 32'h44; wd_t[2] = $urandom;
        we_t[3] = 1'b0; adr_t[3] = BASE + 32'h45; wd_t[3] = 32'h0;
        we_t[4] = 1'b1; adr_t[4] = BASE + 32'h2000; wd_t[4] = $urandom;
        xe_t[0] = 0; xd_t[0] = 0;       lat_t[0] = 2;
        xe_t[1] = 0; xd_t[1] = wd_t[0]; lat_t[1] = 4;
        xe_t[2] = 0; xd_t[2] = 0;       lat_t[2] = 2;
        xe_t[3] = 1; xd_t[3] = 0;       lat_t[3] = 1;
        xe_t[4] = 1; xd_t[4] = 0;       lat_t[4] = 1;
        tick();
        idx = 0; nrsp = 0; acc0 = -1;
        for (int i = 0; i < 5; i++) in_rsp[i] = 0;
        req_valid[1] = 1'b1;
        req_we[1] = we_t[0]; req_addr[1] = adr_t[0];
        req_wdata[1] = wd_t[0];
        for (int cyc = 0; cyc < 100 && nrsp < 5; cyc++) begin
            if (rsp_valid[1]) begin
                ge[nrsp] = rsp_err[1];
                gd[nrsp] = rsp_rdata[1];
                gc[nrsp] = cyc;
                nrsp++;
            end
            acc_now = req_valid[1] && req_ready[1];
            if (acc_now) begin
                in_rsp[idx] = rsp_valid[1];
                if (idx == 0) acc0 = cyc;
            end
            tick();
            if (acc_now) begin
                idx++;
                if (idx < 5) begin
                    req_we[1] = we_t[idx];
                    req_addr[1] = adr_t[idx];
                    req_wdata[1] = wd_t[idx];
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
        end
        req_valid[1] = 1'b0;
        vectors++;
        if (nrsp !== 5 || idx !== 5) begin
            miscompares++;
            $display("FAIL b2b_count rsp=%0d acc=%0d want 5 5", nrsp, idx);
        end else begin
            exp_c = acc0;
            for (int i = 0; i < 5; i++) begin
                exp_c += lat_t[i];
                vectors++;
                if (ge[i] !== xe_t[i] || gd[i] !== xd_t[i]
                    || gc[i] !== exp_c
                    || (i > 0 && in_rsp[i] !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] e=%b d=%h cyc=%0d inrsp=%b want %b %h %0d 1",
                             i, ge[i], gd[i], gc[i], in_rsp[i],
                             xe_t[i], xd_t[i], exp_c);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          kind;
        int          w;
        bit          xe;
        int          xl;
        logic [31:0] xd;
        int          xnwe;
        int          xnrc;
        logic [AW-1:0] ga;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            we   = $urandom_range(0, 1);
            wd   = $urandom;
            w    = $urandom_range(0, WORDS - 1);
            addr = BASE + 32'(w) * 4;
            if (kind <= 3) begin
                we = 1'b1;
            end else if (kind <= 6) begin
                we = 1'b0;
                if (written.size() == 0) we = 1'b1;
                else w = written[$urandom_range(0, written.size() - 1)];
                addr = BASE + 32'(w) * 4;
            end else if (kind == 7) begin
                addr = addr + 32'($urandom_range(1, 3));
            end else if (kind == 8) begin
                if ($urandom_range(0, 1) == 1)
                    addr = BASE + 32'(4 * WORDS)
                         + 32'(4 * $urandom_range(0, 255));
                else
                    addr = BASE - 32'(4 * $urandom_range(1, 64));
            end else begin
                w    = WORDS - 1;
                addr = BASE + 32'(w) * 4;
                if (!model.exists(w)) we = 1'b1;
            end
            xe   = is_err(addr);
            xl   = xe ? 1 : (we ? 2 : 4);
            xd   = (xe || we) ? 32'h0 : model[w];
            xnwe = (!xe && we) ? 1 : 0;
            xnrc = (!xe && !we) ? 3 : 0;
            do_req(1, we, addr, wd);
            vectors++;
            if (r_lat !== xl || r_err !== xe || r_rdata !== xd
                || r_nwe !== xnwe || r_nrc !== xnrc) begin
                miscompares++;
                $display("FAIL rnd[%0d] a=%h we=%b lat=%0d e=%b d=%h nwe=%0d nrc=%0d want %0d %b %h %0d %0d",
                         n, addr, we, r_lat, r_err, r_rdata, r_nwe,
                         r_nrc, xl, xe, xd, xnwe, xnrc);
            end
            if (!xe) begin
                ga = we ? r_waddr : r_raddr;
                vectors++;
                if (ga !== AW'(w) || (we && r_wdin !== wd)) begin
                    miscompares++;
                    $display("FAIL rnd_addr[%0d] ram_addr=%h din=%h want %h %h",
                             n, ga, r_wdin, AW'(w), wd);
                end
                if (we) begin
                    model[w] = wd;
                    written.push_back(w);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        do_req(1, 1'b1, BASE + 32'h80, 32'hA5A5_A5A5);
        do_req(1, 1'b0, BASE + 32'h80, 32'h0);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = BASE + 32'h80;
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        pulses = 0;
        vectors++;
        if ({rsp_valid[1], rsp_err[1], rsp_rdata[1], ram_we[1],
             ram_regce[1], ram_addr[1], ram_din[1]} !== '0
            || req_ready[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid v=%b e=%b d=%h we=%b rce=%b a=%h din=%h rdy=%b want zeros rdy=1",
                     rsp_valid[1], rsp_err[1], rsp_rdata[1], ram_we[1],
                     ram_regce[1], ram_addr[1], ram_din[1],
                     req_ready[1]);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rsp_valid[1]) pulses++;
        end
        rst = 1'b1;
        vectors++;
        if (req_ready[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release req_ready=%b want 1", req_ready[1]);
        end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[1]) pulses++;
            tick();
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL rst_no_rsp pulses=%0d want 0", pulses);
        end
        do_req(1, 1'b0, BASE + 32'h80, 32'h0);
        vectors++;
        if (r_lat !== 4 || r_rdata !== 32'hA5A5_A5A5 || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after lat=%0d d=%h e=%b want 4 a5a5a5a5 0",
                     r_lat, r_rdata, r_err);
        end
    endtask

    task automatic test_read_latency();
        int          k;
        int          lat;
        logic [31:0] wd;
        for (int s = 0; s < 2; s++) begin
            k   = s * 2;
            lat = k + 1;
            wd  = $urandom;
            do_req(k, 1'b1, BASE + 32'h10, wd);
            do_req(k, 1'b0, BASE + 32'h10, 32'h0);
            vectors++;
            if (r_lat !== lat + 2 || r_nrc !== lat + 1
                || r_rdata !== wd || r_err !== 1'b0) begin
                miscompares++;
                $display("FAIL lat%0d lat=%0d nrc=%0d d=%h e=%b want %0d %0d %h 0",
                         lat, r_lat, r_nrc, r_rdata, r_err,
                         lat + 2, lat + 1, wd);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        test_reset();
        test_write_read();
        test_errors();
        test_last_word();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_read_latency();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
